// File: rtl/uif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uif_pkg
// Description : Shared definitions for the USB interface slice: word width,
//               arbiter state encoding and the round-robin pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uif_pkg;

    localparam int USB_WORD_W = 32;
    localparam int RR_MAX_REQ = 8;
    localparam int RR_IDX_W   = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // First requester after 'last' in round-robin order among 'num'
    // requesters (num is a power of two); returns 'last' when nobody asks.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   last,
        input int                    num
    );
        logic [RR_IDX_W-1:0] pick;
        logic [RR_IDX_W-1:0] idx;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX_REQ; i++) begin
            idx = (last + RR_IDX_W'(i)) & RR_IDX_W'(num - 1);
            if (!found && (i <= num) && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_out_fifo
// Description : Small synchronous output FIFO that decouples peripheral read
//               latency from the downstream consumer. Head reads as zero
//               while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_out_fifo
    import uif_pkg::*;
#(
    parameter int  WIDTH   = USB_WORD_W,
    parameter int  DEPTH   = 4,
    localparam int C_PTR_W = $clog2(DEPTH),
    localparam int C_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic [C_CNT_W-1:0] o_count,
    output logic [WIDTH-1:0]   o_head
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A pop on an empty FIFO is dropped so the pointers stay consistent
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && (r_count != C_CNT_W'(DEPTH));

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; stale entries are hidden by the empty mask below
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/periph_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : periph_tx_arbiter
// Description : Round-robin drain of up to eight peripheral TX FIFOs into a
//               single stream of ID-tagged 32-bit words for the FT601
//               controller. Bursts of up to MAX_BURST words per grant.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_tx_arbiter
    import uif_pkg::*;
#(
    parameter int  NUM_PERIPHS = 8,
    parameter int  MAX_BURST   = 16,
    localparam int ID_W        = $clog2(NUM_PERIPHS),
    localparam int PAYLOAD_W   = USB_WORD_W - ID_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PERIPHS-1:0]           periph_empty,
    output logic [NUM_PERIPHS-1:0]           periph_rd,
    input  logic [NUM_PERIPHS*PAYLOAD_W-1:0] periph_data,
    output logic                             periph_data_available,
    input  logic                             read_periph_data,
    output logic [USB_WORD_W-1:0]            periph_word,
    output logic [ID_W-1:0]                  active_periph
);

    localparam int C_BUF_DEPTH = 4;
    localparam int C_BCNT_W    = 8;

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_last_grant;
    logic [ID_W-1:0]       r_inflight_id;
    logic [ID_W-1:0]       w_scan_grant;
    logic [C_BCNT_W-1:0]   r_burst_cnt;
    logic [C_BCNT_W-1:0]   w_burst_cnt_inc;
    logic                  r_inflight;
    logic                  w_any_req;
    logic                  w_rd_en;
    logic                  w_burst_done;
    logic                  w_pop;
    logic [RR_MAX_REQ-1:0] w_req_ext;
    logic [2:0]            w_buf_count;
    logic [3:0]            w_level;
    logic [PAYLOAD_W-1:0]  w_payload [NUM_PERIPHS];
    logic [USB_WORD_W-1:0] w_push_word;

    generate
        for (genvar gi = 0; gi < NUM_PERIPHS; gi++) begin : g_unpack
            assign w_payload[gi] = periph_data[gi*PAYLOAD_W +: PAYLOAD_W];
        end
    endgenerate

    // Round-robin scan starting just after the last completed grant
    always_comb begin
        w_req_ext                  = '0;
        w_req_ext[NUM_PERIPHS-1:0] = ~periph_empty;
        w_scan_grant = ID_W'(rr_next(w_req_ext, RR_IDX_W'(r_last_grant), NUM_PERIPHS));
    end

    assign w_any_req = ~&periph_empty;

    // Read gate uses registered buffer level only, so the consumer's read
    // strobe never reaches periph_rd combinationally.
    assign w_level = 4'(w_buf_count) + 4'(r_inflight);
    assign w_rd_en = (r_state == BURST)
                  && !periph_empty[r_grant]
                  && (r_burst_cnt < C_BCNT_W'(MAX_BURST))
                  && (w_level < 4'(C_BUF_DEPTH));

    // Ending on the read that fills the burst avoids an extra idle cycle
    assign w_burst_cnt_inc = r_burst_cnt + C_BCNT_W'(w_rd_en);
    assign w_burst_done    = periph_empty[r_grant]
                          || (w_burst_cnt_inc >= C_BCNT_W'(MAX_BURST));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req)    w_next_state = BURST;
            BURST:   if (w_burst_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: one-hot read strobe toward the granted peripheral
    always_comb begin
        periph_rd = '0;
        if (w_rd_en) begin
            periph_rd[r_grant] = 1'b1;
        end
    end

    // Grant, burst counter and in-flight tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant       <= '0;
            r_last_grant  <= ID_W'(NUM_PERIPHS - 1);
            r_burst_cnt   <= '0;
            r_inflight    <= 1'b0;
            r_inflight_id <= '0;
        end else begin
            r_inflight    <= w_rd_en;
            r_inflight_id <= r_grant;
            if ((r_state == IDLE) && w_any_req) begin
                r_grant     <= w_scan_grant;
                r_burst_cnt <= '0;
            end
            if (r_state == BURST) begin
                r_burst_cnt <= w_burst_cnt_inc;
                if (w_burst_done) begin
                    r_last_grant <= r_grant;
                end
            end
        end
    end

    assign w_push_word = {r_inflight_id, w_payload[r_inflight_id]};
    assign w_pop       = read_periph_data && periph_data_available;

    arb_out_fifo #(
        .WIDTH (USB_WORD_W),
        .DEPTH (C_BUF_DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (w_push_word),
        .i_pop       (w_pop),
        .o_count     (w_buf_count),
        .o_head      (periph_word)
    );

    assign periph_data_available = (w_buf_count != '0);
    assign active_periph         = r_grant;

endmodule
`default_nettype wire
